// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment scanner: shadow digit store, per-slot blank window,
// leading-zero suppression and registered, polarity-configurable pin outputs.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, nstate;
  logic [CW-1:0]           cnt, ncnt;
  logic [IW-1:0]           idx, nidx;
  logic                    nfd;
  logic [DIGITS-1:0][3:0]  shadow;
  logic [DIGITS-1:0]       dp_sh;
  logic [DIGITS:1]         hi_zero;
  logic [DIGITS-1:0]       supp;
  logic [7:0]              seg_n;
  logic [DIGITS-1:0]       an_n;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  // hi_zero[i]: every nibble from the top down to digit i is zero
  assign hi_zero[DIGITS] = 1'b1;
  assign supp[0]         = 1'b0;
  for (genvar g = DIGITS - 1; g >= 1; g--) begin : g_lz
    assign hi_zero[g] = hi_zero[g+1] & (shadow[g] == 4'h0);
    assign supp[g]    = blank_lz & hi_zero[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      dp_sh      <= '0;
      seg_out    <= SEG_OFF;
      an_out     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      idx        <= nidx;
      seg_out    <= seg_n;
      an_out     <= an_n;
      frame_done <= nfd;
      if (load) begin
        shadow <= data_in;
        dp_sh  <= dp_in;
      end
    end
  end

  always_comb begin
    nstate = IDLE;
    ncnt   = '0;
    nidx   = '0;
    nfd    = 1'b0;
    if (enable) begin
      // IDLE restarts at slot 0 of digit 0 without flagging a frame
      if (state != IDLE) begin
        if (cnt == CW'(REFRESH_DIV - 1)) begin
          if (idx == IW'(DIGITS - 1)) nfd = 1'b1;
          else                        nidx = idx + 1'b1;
        end else begin
          ncnt = cnt + 1'b1;
          nidx = idx;
        end
      end
      nstate = ({1'b0, ncnt} < (CW+1)'(BLANK_CYC)) ? BLANK : SHOW;
    end
  end

  // Output values come from next-state so pins line up with the registered cnt/idx
  always_comb begin
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    if (nstate == SHOW) begin
      an_n  = AN_OFF ^ (DIGITS'(1) << nidx);
      seg_n = SEG_OFF ^ {dp_sh[nidx], supp[nidx] ? 7'h00 : font(shadow[nidx])};
    end
  end
endmodule
